// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell and a carry flip-flop
// process the operands LSB first, one bit per clock. The result is only
// transferred to the outputs once all WIDTH bits are done.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; outputs hold the last result
// RUN     | one operand bit per clock through the full adder
// DONE    | one-cycle result strobe; start here chains the next op
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic [WIDTH-1:0] s,
  output logic             c,
  output logic             ov,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             c_q, c_d;
  logic             ov_q, ov_d;

  logic sum_bit;
  logic carry_nxt;

  // Full-adder cell on the current LSBs of the shifting operand registers.
  always_comb begin
    sum_bit   = a_q[0] ^ b_q[0] ^ carry_q;
    carry_nxt = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
  end

  // Next-state and datapath control; subtraction is a + ~b + 1.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    s_d     = s_q;
    c_d     = c_q;
    ov_d    = ov_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          cnt_d   = '0;
          state_d = ST_RUN;
        end else if (state_q == ST_DONE) begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = carry_nxt;
        sr_d    = {sum_bit, sr_q[WIDTH-1:1]};
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          // carry_q here is the carry into the MSB
          s_d     = {sum_bit, sr_q[WIDTH-1:1]};
          c_d     = carry_nxt;
          ov_d    = carry_q ^ carry_nxt;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sr_q    <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      s_q     <= '0;
      c_q     <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      s_q     <= s_d;
      c_q     <= c_d;
      ov_q    <= ov_d;
    end
  end

  assign s    = s_q;
  assign c    = c_q;
  assign ov   = ov_q;
  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Testbench for serial_adder: a WIDTH=8 and a WIDTH=2 instance share clock and
// reset; results are checked against plain integer arithmetic.
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       start8, cin8, sub8, c8, ov8, busy8, done8;
  logic [7:0] a8, b8, s8;
  logic       start2, cin2, sub2, c2, ov2, busy2, done2;
  logic [1:0] a2, b2, s2;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8), .sub(sub8),
    .s(s8), .c(c8), .ov(ov8), .busy(busy8), .done(done8)
  );

  serial_adder #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .cin(cin2), .sub(sub2),
    .s(s2), .c(c2), .ov(ov2), .busy(busy2), .done(done2)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  logic [31:0] prev_s[2];
  logic [31:0] prev_c[2];
  logic [31:0] prev_ov[2];
  int last_done_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] o_s(input int w);
    return (w == 8) ? {24'b0, s8} : {30'b0, s2};
  endfunction
  function automatic logic [31:0] o_c(input int w);
    return (w == 8) ? 32'(c8) : 32'(c2);
  endfunction
  function automatic logic [31:0] o_ov(input int w);
    return (w == 8) ? 32'(ov8) : 32'(ov2);
  endfunction
  function automatic logic [31:0] o_busy(input int w);
    return (w == 8) ? 32'(busy8) : 32'(busy2);
  endfunction
  function automatic logic [31:0] o_done(input int w);
    return (w == 8) ? 32'(done8) : 32'(done2);
  endfunction

  task automatic drive(input int w, input logic st, input logic [31:0] av, input logic [31:0] bv,
                       input logic cv, input logic sv);
    if (w == 8) begin
      start8 = st; a8 = av[7:0]; b8 = bv[7:0]; cin8 = cv; sub8 = sv;
    end else begin
      start2 = st; a2 = av[1:0]; b2 = bv[1:0]; cin2 = cv; sub2 = sv;
    end
  endtask

  // Reference: unsigned result and carry from plain arithmetic, overflow from
  // the signed interpretation falling outside the representable range.
  function automatic void model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                input logic cv, input logic sv, output logic [31:0] es,
                                output logic [31:0] ec, output logic [31:0] eov);
    longint m, half, ua, ub, sa, sb, r, sr;
    m    = 64'sd1 << w;
    half = m / 2;
    ua   = longint'(av);
    ub   = longint'(bv);
    sa   = (ua >= half) ? ua - m : ua;
    sb   = (ub >= half) ? ub - m : ub;
    if (sv) begin
      r  = ua - ub;
      sr = sa - sb;
      ec = (ua >= ub) ? 32'd1 : 32'd0;
    end else begin
      r  = ua + ub + longint'(cv);
      sr = sa + sb + longint'(cv);
      ec = (r >= m) ? 32'd1 : 32'd0;
    end
    es  = 32'(r & (m - 1));
    eov = (sr > half - 1 || sr < -half) ? 32'd1 : 32'd0;
  endfunction

  // Launch one operation from the current (IDLE or DONE) cycle and follow it
  // to its done pulse, scrambling inputs and start while it runs.
  task automatic do_op(input int w, input logic [31:0] ain, input logic [31:0] bin,
                       input logic cv, input logic sv, input string tag);
    logic [31:0] mask, av, bv, es, ec, eov;
    int idx, lat;
    bit got;
    idx  = (w == 8) ? 0 : 1;
    mask = (32'd1 << w) - 32'd1;
    av   = ain & mask;
    bv   = bin & mask;
    model(w, av, bv, cv, sv, es, ec, eov);
    drive(w, 1'b1, av, bv, cv, sv);
    @(posedge clk); #1;
    chk({tag, ":busy_after_accept"}, o_busy(w), 32'd1);
    chk({tag, ":done_after_accept"}, o_done(w), 32'd0);
    got = 0;
    lat = 0;
    for (int n = 1; n <= 3 * w && !got; n++) begin
      drive(w, 1'($urandom), $urandom, $urandom, 1'($urandom), 1'($urandom));
      @(posedge clk); #1;
      if (o_done(w) == 32'd1) begin
        got = 1;
        lat = n;
        drive(w, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      end else begin
        chk({tag, ":busy_run"}, o_busy(w), 32'd1);
        chk({tag, ":s_hold_run"}, o_s(w), prev_s[idx]);
      end
    end
    drive(w, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk({tag, ":latency"}, 32'(lat), 32'(w));
    if (got) begin
      chk({tag, ":s"}, o_s(w), es);
      chk({tag, ":c"}, o_c(w), ec);
      chk({tag, ":ov"}, o_ov(w), eov);
      chk({tag, ":busy_in_done"}, o_busy(w), 32'd0);
      prev_s[idx]   = es;
      prev_c[idx]   = ec;
      prev_ov[idx]  = eov;
      last_done_cyc = cyc;
    end
  endtask

  task automatic chk_reset_vals(input int w, input string tag);
    chk({tag, ":s"}, o_s(w), 32'd0);
    chk({tag, ":c"}, o_c(w), 32'd0);
    chk({tag, ":ov"}, o_ov(w), 32'd0);
    chk({tag, ":busy"}, o_busy(w), 32'd0);
    chk({tag, ":done"}, o_done(w), 32'd0);
  endtask

  initial begin
    int d1;
    rst = 1'b1;
    drive(8, 1'b1, 32'h12, 32'h34, 1'b0, 1'b0);
    drive(2, 1'b1, 32'd1, 32'd1, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals(8, "rst8");
    chk_reset_vals(2, "rst2");
    for (int i = 0; i < 2; i++) begin
      prev_s[i] = 32'd0; prev_c[i] = 32'd0; prev_ov[i] = 32'd0;
    end
    drive(8, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    drive(2, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_idle8", o_busy(8), 32'd0);

    for (int av = 0; av < 4; av++)
      for (int bv = 0; bv < 4; bv++)
        for (int cv = 0; cv < 2; cv++)
          do_op(2, 32'(av), 32'(bv), 1'(cv), 1'b0, "w2_exh");
    @(posedge clk); #1;
    chk("w2_idle_s", o_s(2), prev_s[1]);

    do_op(8, 32'hFF, 32'h01, 1'b0, 1'b0, "add_ff_01");
    do_op(8, 32'h7F, 32'h01, 1'b1, 1'b0, "add_ovf");
    do_op(8, 32'h05, 32'h07, 1'b1, 1'b1, "sub_5_7");
    do_op(8, 32'h80, 32'h01, 1'b0, 1'b1, "sub_80_01");

    repeat (3) begin
      @(posedge clk); #1;
      chk("idle_s_hold", o_s(8), prev_s[0]);
      chk("idle_c_hold", o_c(8), prev_c[0]);
      chk("idle_ov_hold", o_ov(8), prev_ov[0]);
      chk("idle_done", o_done(8), 32'd0);
    end

    do_op(8, 32'h3A, 32'hC5, 1'b1, 1'b0, "b2b_1");
    d1 = last_done_cyc;
    do_op(8, 32'h10, 32'h20, 1'b0, 1'b1, "b2b_2");
    chk("b2b_done_spacing", 32'(last_done_cyc - d1), 32'd9);

    for (int i = 0; i < 20; i++) begin
      do_op(8, $urandom, $urandom, 1'($urandom), 1'($urandom), "rand");
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    drive(8, 1'b1, 32'h3C, 32'h5A, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(8, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    drive(8, 1'b1, 32'h11, 32'h22, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk_reset_vals(8, "rst_mid");
    @(posedge clk); #1;
    chk("rst_start_discard", o_busy(8), 32'd0);
    rst = 1'b0;
    drive(8, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      prev_s[i] = 32'd0; prev_c[i] = 32'd0; prev_ov[i] = 32'd0;
    end
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      chk("rst_no_done", o_done(8), 32'd0);
      chk("rst_s_zero", o_s(8), 32'd0);
    end
    do_op(8, 32'hA5, 32'h5B, 1'b0, 1'b0, "after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
